// File: rtl/usb_pid_pkg.sv
// Shared USB PID definitions: PID code enum, receive FSM states, legality
// and bit-order helpers used by the PID receive tracker.
package usb_pid_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_SETUP = 4'b1101
  } pid_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_DONE
  } rx_state_t;

  // The shifter delivers bits in wire order, so each nibble arrives mirrored.
  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    return {rev4(v[3:0]), rev4(v[7:4])};
  endfunction

  function automatic logic pid_legal(input logic [3:0] pid, input logic ext);
    logic ok;
    ok = 1'b0;
    case (pid)
      PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK: ok = 1'b1;
      PID_NAK, PID_STALL, PID_SETUP:                  ok = ext;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic pid_is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/pid_toggle_bank.sv
// Per-endpoint expected DATA0/DATA1 toggle flops with a combinational read
// of the selected endpoint; out-of-range selects read 0 and write nothing.
module pid_toggle_bank
  import usb_pid_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EP_W   = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [EP_W-1:0] ep_sel,
  input  logic            tog_adv,
  input  logic            tog_clr,
  output logic            tog_exp
);

  logic [NUM_EP-1:0] tog_vec;

  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
    logic hit;
    logic tog_q;

    assign hit = (int'(ep_sel) == gi);

    // Clear dominates advance when both arrive together.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        tog_q <= 1'b0;
      end else if (hit && tog_clr) begin
        tog_q <= 1'b0;
      end else if (hit && tog_adv) begin
        tog_q <= ~tog_q;
      end
    end

    assign tog_vec[gi] = tog_q;
  end

  always_comb begin
    tog_exp = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (int'(ep_sel) == i) tog_exp = tog_vec[i];
    end
  end

endmodule

// File: rtl/pid_rx_tracker.sv
// PID receive tracker: captures the PID byte, checks/classifies it, tracks
// data toggles and counts errors. PID_EXT_EN adds NAK/STALL/SETUP as legal.
module pid_rx_tracker
  import usb_pid_pkg::*;
#(
  parameter int NUM_EP    = 4,
  parameter int EP_W      = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [7:0]           rcv_data,
  input  logic                 PID_mode,
  input  logic                 PID_clear,
  input  logic [EP_W-1:0]      ep_sel,
  input  logic                 tog_adv,
  input  logic                 tog_clr,
  input  logic                 err_clr,
  output logic [3:0]           rx_packet,
  output logic [3:0]           PID_byte,
  output logic                 PID_valid,
  output logic                 PID_err,
  output logic                 chk_err,
  output logic                 seq_err,
  output logic                 tog_exp,
  output logic [ERR_CNT_W-1:0] err_count
);

`ifdef PID_EXT_EN
  localparam logic EXT_LEGAL = 1'b1;
`else
  localparam logic EXT_LEGAL = 1'b0;
`endif

  rx_state_t            state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 pid_err_q, pid_err_d;
  logic                 chk_err_q, chk_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] pid_w, check_w;
  logic       chk_bad, illegal, seq_bad, eval;

  pid_toggle_bank #(
    .NUM_EP (NUM_EP),
    .EP_W   (EP_W)
  ) u_tog (
    .clk     (clk),
    .n_rst   (n_rst),
    .ep_sel  (ep_sel),
    .tog_adv (tog_adv),
    .tog_clr (tog_clr),
    .tog_exp (tog_exp)
  );

  assign pid_w   = rev4(hold_q[7:4]);
  assign check_w = rev4(hold_q[3:0]);
  assign chk_bad = (check_w != ~pid_w);
  assign illegal = !pid_legal(pid_w, EXT_LEGAL);
  // A corrupted PID cannot be trusted to carry a meaningful toggle bit.
  assign seq_bad = !chk_bad && pid_is_data(pid_w) && (pid_w[3] != tog_exp);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pid_err_d = pid_err_q;
    chk_err_d = chk_err_q;
    seq_err_d = seq_err_q;
    err_cnt_d = err_cnt_q;
    eval      = 1'b0;

    case (state_q)
      ST_IDLE: if (PID_mode) begin
        hold_d  = rcv_data;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        eval    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (PID_mode) begin
          hold_d  = rcv_data;
          state_d = ST_CAPT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops any pending evaluation; a simultaneous capture still starts.
    if (PID_clear) begin
      eval      = 1'b0;
      pid_err_d = 1'b0;
      chk_err_d = 1'b0;
      seq_err_d = 1'b0;
      if (PID_mode) begin
        hold_d  = rcv_data;
        state_d = ST_CAPT;
      end else begin
        hold_d  = 8'hFF;
        state_d = ST_IDLE;
      end
    end

    if (eval) begin
      pid_err_d = illegal | chk_bad;
      chk_err_d = chk_bad;
      seq_err_d = seq_bad;
      if ((illegal | chk_bad | seq_bad) && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end

    if (err_clr) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= 8'hFF;
      pid_err_q <= 1'b0;
      chk_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pid_err_q <= pid_err_d;
      chk_err_q <= chk_err_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_packet = pid_w;
  assign PID_byte  = pid_w;
  assign PID_valid = (state_q == ST_DONE);
  assign PID_err   = pid_err_q;
  assign chk_err   = chk_err_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_cnt_q;

endmodule
